// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding tracker for a classic 5-stage pipeline.
// Shadows the EX/MEM/WB destination info, selects forwarding sources for the
// EX operands, raises a one-cycle load-use stall and counts stall cycles.
module hazard_forward_unit #(
  parameter int RWIDTH = 5,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_en,
  input  logic [RWIDTH-1:0] id_rs,
  input  logic [RWIDTH-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [RWIDTH-1:0] id_wreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [CWIDTH-1:0] stall_count
);

  // Forwarding select encodings.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // EX stage shadow
  logic [RWIDTH-1:0] ex_rs_reg;
  logic [RWIDTH-1:0] ex_rt_reg;
  logic [RWIDTH-1:0] ex_wreg_reg;
  logic              ex_regwrite_reg;
  logic              ex_memread_reg;
  // MEM stage shadow
  logic [RWIDTH-1:0] mem_wreg_reg;
  logic              mem_regwrite_reg;
  logic              mem_memread_reg;
  // WB stage shadow
  logic [RWIDTH-1:0] wb_wreg_reg;
  logic              wb_regwrite_reg;

  logic [CWIDTH-1:0] stall_count_reg;
  logic [CWIDTH-1:0] stall_count_next;

  // mem_memread is tracked so the MEM shadow mirrors the real pipeline, but
  // no decision here needs it today.
  logic mem_memread_unused;
  assign mem_memread_unused = mem_memread_reg;

  // A load in EX whose result the ID instruction needs cannot be forwarded in
  // time; the data only exists after MEM, so hold ID one cycle.
  assign stall = ex_memread_reg && ex_regwrite_reg && (ex_wreg_reg != '0) &&
                 ((id_rs_used && (id_rs == ex_wreg_reg)) ||
                  (id_rt_used && (id_rt == ex_wreg_reg)));

  // Saturating increment: stop at all-ones rather than wrapping to zero.
  assign stall_count_next = (&stall_count_reg) ? stall_count_reg
                                               : stall_count_reg + 1'b1;

  // Operand forwarding: index 0 is operand A (rs), index 1 is operand B (rt).
  // MEM is checked first so the most recent producer wins; register 0 is
  // hard-wired and never forwarded.
  logic [RWIDTH-1:0] ex_src [2];
  logic [1:0]        fwd_sel [2];
  assign ex_src[0] = ex_rs_reg;
  assign ex_src[1] = ex_rt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      assign mem_hit = mem_regwrite_reg && (mem_wreg_reg != '0) &&
                       (mem_wreg_reg == ex_src[gi]);
      assign wb_hit  = wb_regwrite_reg && (wb_wreg_reg != '0) &&
                       (wb_wreg_reg == ex_src[gi]);
      assign fwd_sel[gi] = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
    end
  endgenerate

  assign forward_a   = fwd_sel[0];
  assign forward_b   = fwd_sel[1];
  assign stall_count = stall_count_reg;

  // Stage shadow registers: advance on pipe_en, bubble EX while stalling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs_reg        <= '0;
      ex_rt_reg        <= '0;
      ex_wreg_reg      <= '0;
      ex_regwrite_reg  <= 1'b0;
      ex_memread_reg   <= 1'b0;
      mem_wreg_reg     <= '0;
      mem_regwrite_reg <= 1'b0;
      mem_memread_reg  <= 1'b0;
      wb_wreg_reg      <= '0;
      wb_regwrite_reg  <= 1'b0;
    end else if (pipe_en) begin
      if (stall) begin
        // Bubble: the control bits are what matter; operand fields are cleared
        // only to keep the idle EX stage deterministic.
        ex_rs_reg       <= '0;
        ex_rt_reg       <= '0;
        ex_wreg_reg     <= '0;
        ex_regwrite_reg <= 1'b0;
        ex_memread_reg  <= 1'b0;
      end else begin
        ex_rs_reg       <= id_rs;
        ex_rt_reg       <= id_rt;
        ex_wreg_reg     <= id_wreg;
        ex_regwrite_reg <= id_regwrite;
        ex_memread_reg  <= id_memread;
      end
      mem_wreg_reg     <= ex_wreg_reg;
      mem_regwrite_reg <= ex_regwrite_reg;
      mem_memread_reg  <= ex_memread_reg;
      wb_wreg_reg      <= mem_wreg_reg;
      wb_regwrite_reg  <= mem_regwrite_reg;
    end
  end

  // Load-use stall counter, frozen along with the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_reg <= '0;
    end else if (pipe_en && stall) begin
      stall_count_reg <= stall_count_next;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed testbench for hazard_forward_unit: one task per scenario, a default
// instance plus a CWIDTH=2 instance sharing stimulus for counter saturation.
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst;
  logic       pipe_en;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic [4:0] id_wreg;
  logic       id_regwrite;
  logic       id_memread;
  logic [1:0] fa, fb, fa2, fb2;
  logic       st, st2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  hazard_forward_unit #(.RWIDTH(5), .CWIDTH(16)) dut (
    .clk(clk), .rst(rst), .pipe_en(pipe_en),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .forward_a(fa), .forward_b(fb), .stall(st), .stall_count(cnt)
  );

  hazard_forward_unit #(.RWIDTH(5), .CWIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .pipe_en(pipe_en),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .forward_a(fa2), .forward_b(fb2), .stall(st2), .stall_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] sat2(input int v);
    return (v >= 3) ? 2'd3 : v[1:0];
  endfunction

  task automatic issue(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic [4:0] wreg, input logic rw,
                       input logic mr);
    id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wreg = wreg; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic nop();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pipe_en = 1'b1;
    issue(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1);
    repeat (2) tick();
    checks++; if (fa !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b expected 00", fa); end
    checks++; if (fb !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b expected 00", fb); end
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", st); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_count_small: got %0d expected 0", cnt2); end
    nop();
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_ex_mem_forward();
    flush();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);  // I1 writes r3
    tick();
    issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);  // I2 reads r3, r4
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL exmem_no_stall: got %b expected 0", st); end
    tick();
    checks++; if (fa !== 2'b10) begin errors++; $display("FAIL exmem_fwd_a: got %b expected 10", fa); end
    checks++; if (fb !== 2'b00) begin errors++; $display("FAIL exmem_fwd_b: got %b expected 00", fb); end
    checks++; if (fa2 !== 2'b10) begin errors++; $display("FAIL exmem_fwd_a_small: got %b expected 10", fa2); end
  endtask

  task automatic test_mem_wb_priority();
    // Both older instructions write r5: MEM must win over WB.
    flush();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    issue(5'd9, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    checks++; if (fb !== 2'b10) begin errors++; $display("FAIL prio_fwd_b: got %b expected 10", fb); end
    checks++; if (fa !== 2'b00) begin errors++; $display("FAIL prio_fwd_a: got %b expected 00", fa); end
    // I2 writes r6 instead: r5 now only in WB, r6 in MEM.
    flush();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    issue(5'd6, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    checks++; if (fb !== 2'b01) begin errors++; $display("FAIL memwb_fwd_b: got %b expected 01", fb); end
    checks++; if (fa !== 2'b10) begin errors++; $display("FAIL memwb_fwd_a: got %b expected 10", fa); end
    tick();  // r6 producer now in WB, r5 producer retired
    checks++; if (fa !== 2'b01) begin errors++; $display("FAIL wb_only_fwd_a: got %b expected 01", fa); end
  endtask

  task automatic test_load_use();
    flush();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);  // load r7
    tick();
    issue(5'd7, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0); // user of r7
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b expected 1", st); end
    checks++; if (st2 !== 1'b1) begin errors++; $display("FAIL loaduse_stall_small: got %b expected 1", st2); end
    tick();
    exp_cnt++;
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL loaduse_one_cycle: got %b expected 0", st); end
    checks++; if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL loaduse_count: got %0d expected %0d", cnt, exp_cnt); end
    tick();
    checks++; if (fa !== 2'b01) begin errors++; $display("FAIL loaduse_fwd_a: got %b expected 01", fa); end
    checks++; if (fb !== 2'b00) begin errors++; $display("FAIL loaduse_fwd_b: got %b expected 00", fb); end
    nop();
  endtask

  task automatic test_reg_zero();
    flush();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // writes r0
    tick();
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
    tick();
    checks++; if (fa !== 2'b00) begin errors++; $display("FAIL zero_fwd_a: got %b expected 00", fa); end
    checks++; if (fb !== 2'b00) begin errors++; $display("FAIL zero_fwd_b: got %b expected 00", fb); end
    flush();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);  // load into r0
    tick();
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b expected 0", st); end
    tick();
    checks++; if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL zero_count: got %0d expected %0d", cnt, exp_cnt); end
    nop();
  endtask

  task automatic test_freeze_reset();
    flush();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);  // load r9
    tick();
    issue(5'd1, 1'b0, 5'd9, 1'b1, 5'd13, 1'b1, 1'b0); // reads r9 via rt
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL freeze_stall[%0d]: got %b expected 1", i, st); end
      checks++; if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL freeze_count[%0d]: got %0d expected %0d", i, cnt, exp_cnt); end
    end
    #2;
    rst = 1'b1;  // asynchronous, mid-cycle
    #1;
    exp_cnt = 0;
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL async_rst_stall: got %b expected 0", st); end
    checks++; if (fa !== 2'b00) begin errors++; $display("FAIL async_rst_fwd_a: got %b expected 00", fa); end
    checks++; if (fb !== 2'b00) begin errors++; $display("FAIL async_rst_fwd_b: got %b expected 00", fb); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL async_rst_count: got %0d expected 0", cnt); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL async_rst_count_small: got %0d expected 0", cnt2); end
    @(negedge clk);
    rst = 1'b0;
    pipe_en = 1'b1;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);  // load r2 on first edge
    tick();
    issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL post_rst_load: got %b expected 1", st); end
    nop();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    flush();
    for (int i = 0; i < 5; i++) begin
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
      tick();
      exp_cnt++;
      nop();
      tick();
      checks++; if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sat_count_wide[%0d]: got %0d expected %0d", i, cnt, exp_cnt); end
      checks++; if (cnt2 !== sat2(exp_cnt)) begin errors++; $display("FAIL sat_count_small[%0d]: got %0d expected %0d", i, cnt2, sat2(exp_cnt)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    pipe_en = 1'b1;
    id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_wreg = '0; id_regwrite = 1'b0; id_memread = 1'b0;
    test_reset();
    test_ex_mem_forward();
    test_mem_wb_priority();
    test_load_use();
    test_reg_zero();
    test_freeze_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
